// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared ISA definitions for the ID-stage interlock logic: instruction field
// layout, SPECIAL-opcode funct codes for the HI/LO and mul/div instructions,
// and the mul/div occupancy timer state type.
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  // Counter width for the mul/div timer; holds latencies up to 64 cycles.
  localparam int MD_CNT_W = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // R-type field layout; rs/rt sit in the same position for every format.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } isa_fields_t;

  function automatic isa_fields_t isa_fields(input logic [31:0] instr);
    return isa_fields_t'(instr);
  endfunction

  function automatic logic [4:0] instr_rs(input isa_fields_t f);
    return f.rs;
  endfunction

  function automatic logic [4:0] instr_rt(input isa_fields_t f);
    return f.rt;
  endfunction

endpackage

// File: rtl/hazard_unit_md_timer.sv
// -----------------------------------------------------------------------------
// md_timer
// Occupancy timer for the iterative multiply/divide unit. busy is high for
// exactly MULT_LAT (isDiv=0) or DIV_LAT (isDiv=1) cycles, starting the cycle
// after start is sampled. start is ignored while busy.
//
// state   | meaning
// --------+------------------------------------------------------------
// MD_IDLE | unit free, HI/LO valid, waiting for a mul/div in EX
// MD_BUSY | operation in flight; cnt_q counts remaining cycles minus one
//
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset
//   start  in   valid mult/multu/div/divu in EX this cycle
//   isDiv  in   1 = div/divu, 0 = mult/multu (qualifies start)
//   busy   out  unit occupied
// -----------------------------------------------------------------------------
module md_timer
  import hazard_unit_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic isDiv,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_LAT - 1);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_LAT - 1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = isDiv ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        // Terminal count: the current cycle is the last busy one.
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// ID-stage interlock controller for the five-stage MIPS core. Covers the
// hazards forwarding cannot: load-use, HI/LO access or new mul/div while the
// iterative mul/div unit is busy, and wrong-path fetch after a taken branch.
// Also counts cycles in which the PC was held.
//
// Ports:
//   clk            in   core clock
//   rst_n          in   asynchronous active-low reset
//   idInstruction  in   instruction word in ID
//   exWriteReg     in   EX destination register (0 = none)
//   exMemRead      in   EX instruction is a load
//   exIsMulDiv     in   EX holds a valid mult/multu/div/divu
//   exIsDiv        in   qualifies exIsMulDiv: 1 = div/divu
//   branchTaken    in   branch/jump resolved taken in EX
//   pcStall        out  hold PC
//   ifidStall      out  hold IF/ID
//   ifidFlush      out  squash IF/ID
//   idexBubble     out  load nop into ID/EX
//   mdBusy         out  mul/div unit occupied, HI/LO not valid
//   stallCount     out  number of cycles with pcStall asserted (wraps)
// -----------------------------------------------------------------------------
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] idInstruction,
  input  logic [4:0]  exWriteReg,
  input  logic        exMemRead,
  input  logic        exIsMulDiv,
  input  logic        exIsDiv,
  input  logic        branchTaken,
  output logic        pcStall,
  output logic        ifidStall,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic        mdBusy,
  output logic [31:0] stallCount
);

  isa_fields_t id_f;
  logic [4:0]  id_rs, id_rt;
  logic        id_special;
  logic        id_uses_hilo, id_is_muldiv;
  logic        load_use, hilo_stall, stall;
  logic        unused_id_bits;
  logic [31:0] stall_count_q, stall_count_d;

  assign id_f  = isa_fields(idInstruction);
  assign id_rs = instr_rs(id_f);
  assign id_rt = instr_rt(id_f);

  // rd/shamt play no part in interlock decisions.
  assign unused_id_bits = ^{id_f.rd, id_f.shamt};

  assign id_special   = (id_f.opcode == OP_SPECIAL);
  assign id_uses_hilo = id_special &&
                        ((id_f.funct == FN_MFHI) || (id_f.funct == FN_MFLO) ||
                         (id_f.funct == FN_MTHI) || (id_f.funct == FN_MTLO));
  assign id_is_muldiv = id_special &&
                        ((id_f.funct == FN_MULT) || (id_f.funct == FN_MULTU) ||
                         (id_f.funct == FN_DIV)  || (id_f.funct == FN_DIVU));

  // Both source fields are compared whatever the format; a false match only
  // costs one cycle.
  assign load_use   = exMemRead && (exWriteReg != 5'd0) &&
                      ((exWriteReg == id_rs) || (exWriteReg == id_rt));
  assign hilo_stall = mdBusy && (id_uses_hilo || id_is_muldiv);

  // A taken branch wins: the ID instruction is wrong-path, so it is flushed
  // rather than held. All controls are quiet while in reset.
  assign stall      = (load_use || hilo_stall) && !branchTaken && rst_n;
  assign pcStall    = stall;
  assign ifidStall  = stall;
  assign ifidFlush  = branchTaken && rst_n;
  assign idexBubble = (stall || branchTaken) && rst_n;

  md_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (exIsMulDiv),
    .isDiv (exIsDiv),
    .busy  (mdBusy)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (pcStall) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  localparam logic [31:0] I_NOP      = 32'h0000_0000;
  localparam logic [31:0] I_ADD_981  = 32'h0101_4820; // add $9,$8,$1
  localparam logic [31:0] I_ADD_900  = 32'h0000_4820; // add $9,$0,$0
  localparam logic [31:0] I_LW_8_1   = 32'h8C28_0000; // lw $8,0($1)
  localparam logic [31:0] I_MFHI     = 32'h0000_1010; // mfhi $2
  localparam logic [31:0] I_MFLO     = 32'h0000_1812; // mflo $3
  localparam logic [31:0] I_MULT     = 32'h0085_0018; // mult $4,$5
  localparam logic [31:0] I_ADDI_F10 = 32'h2041_0010; // addi, low bits look like mfhi

  logic        clk;
  logic        rst_n;
  logic [31:0] idInstruction;
  logic [4:0]  exWriteReg;
  logic        exMemRead;
  logic        exIsMulDiv;
  logic        exIsDiv;
  logic        branchTaken;
  logic        pcStall, ifidStall, ifidFlush, idexBubble, mdBusy;
  logic [31:0] stallCount;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles of the mul/div unit and the
  // expected stall counter.
  int          m_md_left = 0;
  logic [31:0] m_count   = 32'd0;

  hazard_unit #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .idInstruction (idInstruction),
    .exWriteReg    (exWriteReg),
    .exMemRead     (exMemRead),
    .exIsMulDiv    (exIsMulDiv),
    .exIsDiv       (exIsDiv),
    .branchTaken   (branchTaken),
    .pcStall       (pcStall),
    .ifidStall     (ifidStall),
    .ifidFlush     (ifidFlush),
    .idexBubble    (idexBubble),
    .mdBusy        (mdBusy),
    .stallCount    (stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_comb(output logic s, output logic f, output logic b);
    int  op, rs, rt, fn;
    bit  hilo, muldiv, lu, hs;
    op     = int'(idInstruction >> 26);
    rs     = int'((idInstruction >> 21) & 32'd31);
    rt     = int'((idInstruction >> 16) & 32'd31);
    fn     = int'(idInstruction & 32'd63);
    hilo   = (op == 0) && (fn >= 16) && (fn <= 19);
    muldiv = (op == 0) && (fn >= 24) && (fn <= 27);
    lu     = exMemRead && (exWriteReg != 5'd0) &&
             ((int'(exWriteReg) == rs) || (int'(exWriteReg) == rt));
    hs     = (m_md_left > 0) && (hilo || muldiv);
    s      = rst_n && !branchTaken && (lu || hs);
    f      = rst_n && branchTaken;
    b      = rst_n && (branchTaken || s);
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [4:0] wr, input logic mr,
                       input logic md, input logic dv, input logic br);
    idInstruction = ins;
    exWriteReg    = wr;
    exMemRead     = mr;
    exIsMulDiv    = md;
    exIsDiv       = dv;
    branchTaken   = br;
    #1;
  endtask

  task automatic check_outputs();
    logic s, f, b;
    model_comb(s, f, b);
    chk("pcStall",    32'(pcStall),    32'(s));
    chk("ifidStall",  32'(ifidStall),  32'(s));
    chk("ifidFlush",  32'(ifidFlush),  32'(f));
    chk("idexBubble", 32'(idexBubble), 32'(b));
    chk("mdBusy",     32'(mdBusy),     32'(rst_n && (m_md_left > 0)));
    chk("stallCount", stallCount,      m_count);
  endtask

  task automatic tick();
    logic s, f, b;
    model_comb(s, f, b);
    @(posedge clk);
    if (rst_n) begin
      if (s) m_count = m_count + 32'd1;
      if (m_md_left > 0) m_md_left = m_md_left - 1;
      else if (exIsMulDiv) m_md_left = exIsDiv ? DIV_LAT : MULT_LAT;
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic [31:0] ins, input logic [4:0] wr, input logic mr,
                       input logic md, input logic dv, input logic br);
    drive(ins, wr, mr, md, dv, br);
    check_outputs();
    tick();
  endtask

  // Assert reset at a negedge, check the asynchronous effect, release at the
  // next negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_md_left = 0;
    m_count   = 32'd0;
    chk("rst_mdBusy",     32'(mdBusy),     32'd0);
    chk("rst_stallCount", stallCount,      32'd0);
    chk("rst_pcStall",    32'(pcStall),    32'd0);
    chk("rst_idexBubble", 32'(idexBubble), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  wr;
    logic        mr;
    logic        br;
    logic        stall;
    logic        flush;
    logic        bubble;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{I_ADD_981, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // rs match
    vecs[1] = '{I_ADD_981, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // rt match
    vecs[2] = '{I_ADD_981, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // rd only
    vecs[3] = '{I_ADD_981, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // not a load
    vecs[4] = '{I_ADD_900, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // $0 never stalls
    vecs[5] = '{I_ADD_981, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}; // branch wins
    vecs[6] = '{I_NOP,     5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{I_LW_8_1,  5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // I-type rs
    vecs[8] = '{I_MFHI,    5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle unit

    rst_n = 1'b0;
    idInstruction = '0; exWriteReg = '0; exMemRead = 1'b0;
    exIsMulDiv = 1'b0; exIsDiv = 1'b0; branchTaken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Table vectors with the mul/div unit idle.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].instr, vecs[i].wr, vecs[i].mr, 1'b0, 1'b0, vecs[i].br);
      chk($sformatf("vec%0d_stall", i),  32'(pcStall),    32'(vecs[i].stall));
      chk($sformatf("vec%0d_flush", i),  32'(ifidFlush),  32'(vecs[i].flush));
      chk($sformatf("vec%0d_bubble", i), 32'(idexBubble), 32'(vecs[i].bubble));
      check_outputs();
      tick();
    end

    // Load-use lasts one cycle.
    do_reset();
    cycle(I_ADD_981, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(I_ADD_981, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_count", stallCount, 32'd1);
    @(negedge clk);

    // div then mflo: 32 stall cycles.
    do_reset();
    cycle(I_NOP, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= DIV_LAT; i++) begin
      drive(I_MFLO, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("div_busy_c%0d", i),  32'(mdBusy),  32'd1);
      chk($sformatf("div_stall_c%0d", i), 32'(pcStall), 32'd1);
      check_outputs();
      tick();
    end
    drive(I_MFLO, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("div_done_busy",  32'(mdBusy),  32'd0);
    chk("div_done_stall", 32'(pcStall), 32'd0);
    chk("div_count",      stallCount,   32'd32);
    check_outputs();
    tick();

    // mult, then a mult held in ID, then the second mult occupies the unit.
    do_reset();
    cycle(I_NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= MULT_LAT; i++) begin
      drive(I_MULT, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("mm_stall_c%0d", i), 32'(pcStall), 32'd1);
      check_outputs();
      tick();
    end
    drive(I_MULT, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mm_release", 32'(pcStall), 32'd0);
    check_outputs();
    tick();
    cycle(I_NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= MULT_LAT; i++) begin
      drive(I_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("mm2_busy_c%0d", i), 32'(mdBusy), 32'd1);
      check_outputs();
      tick();
    end
    drive(I_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mm2_idle", 32'(mdBusy), 32'd0);
    chk("mm_count", stallCount,  32'd4);
    tick();

    // Taken branch while busy with mfhi in ID; non-SPECIAL lookalike never stalls.
    do_reset();
    cycle(I_NOP, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(I_MFHI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("br_flush",  32'(ifidFlush),  32'd1);
    chk("br_bubble", 32'(idexBubble), 32'd1);
    chk("br_stall",  32'(pcStall),    32'd0);
    check_outputs();
    tick();
    cycle(I_ADDI_F10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("br_count", stallCount, 32'd0);
    @(negedge clk);

    // Reset in the middle of a div.
    do_reset();
    cycle(I_NOP, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) cycle(I_MFLO, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(I_MFHI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_stall", 32'(pcStall), 32'd0);
    check_outputs();
    tick();

    // stallCount wrap.
    do_reset();
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1 release dut.stall_count_q;
    m_count = 32'hFFFF_FFFE;
    cycle(I_ADD_981, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(I_ADD_981, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("wrap_zero", stallCount, 32'd0);
    @(negedge clk);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      logic [4:0]  rs, rt;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ins = {6'h00, rs, rt, 5'($urandom), 5'd0, 6'h10 + 6'($urandom_range(0, 3))};
        1: ins = {6'h00, rs, rt, 10'd0, 6'h18 + 6'($urandom_range(0, 3))};
        2: ins = {6'h00, rs, rt, 5'($urandom), 5'($urandom), 6'($urandom)};
        3: ins = {6'($urandom_range(1, 63)), rs, rt, 16'($urandom)};
        4: ins = 32'($urandom);
        default: ins = I_NOP;
      endcase
      cycle(ins, 5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
